// File: rtl/checker_multi_cmp.sv
// Multi-channel behavioural-vs-structural comparator: per-channel and global match flags,
// sticky error, saturating mismatch counter and a frozen record of the first failure.
module checker_multi_cmp #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ARM_DELAY  = 2,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            valid_c,
  input  logic [CHANNELS-1:0]            valid_e,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_c,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_e,
  output logic [CHANNELS-1:0]            ch_match,
  output logic                           checks_out,
  output logic                           err_pulse,
  output logic                           err_sticky,
  output logic [CNT_WIDTH-1:0]           mismatch_count,
  output logic [CNT_WIDTH-1:0]           first_err_cycle,
  output logic [CH_W-1:0]                first_err_chan,
  output logic [DATA_WIDTH-1:0]          first_err_c,
  output logic [DATA_WIDTH-1:0]          first_err_e
);

  typedef enum logic [1:0] {StArming, StArmed, StFailed} state_e;

  state_e                r_state;
  logic [7:0]            r_arm_cnt;
  logic [CNT_WIDTH-1:0]  r_cycle;
  logic [CHANNELS-1:0]   r_ch_match;
  logic                  r_checks;
  logic                  r_err_pulse;
  logic                  r_err_sticky;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_first_cycle;
  logic [CH_W-1:0]       r_first_chan;
  logic [DATA_WIDTH-1:0] r_first_c;
  logic [DATA_WIDTH-1:0] r_first_e;

  logic [CHANNELS-1:0]   w_mis;
  logic                  w_any_mis;
  logic                  w_armed;
  logic                  w_capture;
  logic [CH_W-1:0]       w_first_chan;
  logic [DATA_WIDTH-1:0] w_first_c;
  logic [DATA_WIDTH-1:0] w_first_e;

  // Case inequality so that any X on an armed input is reported as a mismatch.
  always_comb begin
    w_mis = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_mis[i] = (valid_c[i] !== valid_e[i]) ||
                 ((valid_c[i] & valid_e[i]) &&
                  (data_c[i*DATA_WIDTH +: DATA_WIDTH] !== data_e[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Descending scan leaves the lowest failing channel selected.
  always_comb begin
    w_first_chan = '0;
    w_first_c    = data_c[DATA_WIDTH-1:0];
    w_first_e    = data_e[DATA_WIDTH-1:0];
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_mis[i]) begin
        w_first_chan = CH_W'(i);
        w_first_c    = data_c[i*DATA_WIDTH +: DATA_WIDTH];
        w_first_e    = data_e[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_any_mis = |w_mis;
  // The cycle on which the arming count completes is already the first compared cycle.
  assign w_armed   = (r_state != StArming) || (r_arm_cnt == 8'(ARM_DELAY));
  assign w_capture = w_armed && (r_state != StFailed) && w_any_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StArming;
      r_arm_cnt     <= '0;
      r_cycle       <= '0;
      r_ch_match    <= '1;
      r_checks      <= 1'b1;
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_count       <= '0;
      r_first_cycle <= '0;
      r_first_chan  <= '0;
      r_first_c     <= '0;
      r_first_e     <= '0;
    end else if (!w_armed) begin
      r_arm_cnt   <= r_arm_cnt + 8'd1;
      r_ch_match  <= '1;
      r_checks    <= 1'b1;
      r_err_pulse <= 1'b0;
    end else begin
      r_ch_match  <= ~w_mis;
      r_checks    <= ~w_any_mis;
      r_err_pulse <= w_any_mis;
      if (r_cycle != '1) begin
        r_cycle <= r_cycle + CNT_WIDTH'(1);
      end
      if (w_any_mis) begin
        r_err_sticky <= 1'b1;
        if (r_count != '1) begin
          r_count <= r_count + CNT_WIDTH'(1);
        end
      end
      if (w_capture) begin
        r_state       <= StFailed;
        r_first_cycle <= r_cycle;
        r_first_chan  <= w_first_chan;
        r_first_c     <= w_first_c;
        r_first_e     <= w_first_e;
      end else if (r_state == StArming) begin
        r_state <= StArmed;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_capture) begin
      $display("checker_multi_cmp: first mismatch at %0t chan=%0d c=%h e=%h",
               $time, w_first_chan, w_first_c, w_first_e);
    end
  end
`endif

  assign ch_match        = r_ch_match;
  assign checks_out      = r_checks;
  assign err_pulse       = r_err_pulse;
  assign err_sticky      = r_err_sticky;
  assign mismatch_count  = r_count;
  assign first_err_cycle = r_first_cycle;
  assign first_err_chan  = r_first_chan;
  assign first_err_c     = r_first_c;
  assign first_err_e     = r_first_e;

endmodule

// File: tb/tb_checker_multi_cmp.sv
// Bench for checker_multi_cmp: two instances (ARM_DELAY=2/CNT_WIDTH=16 and ARM_DELAY=0/CNT_WIDTH=4)
// checked every cycle against a reference model, plus hand-computed literal expectations.
module tb_checker_multi_cmp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  valid_c, valid_e;
  logic [15:0] data_c, data_e;

  logic [3:0]  a_ch_match, b_ch_match;
  logic        a_checks, b_checks, a_pulse, b_pulse, a_sticky, b_sticky;
  logic [15:0] a_count, a_fcyc;
  logic [3:0]  b_count, b_fcyc;
  logic [1:0]  a_fchan, b_fchan;
  logic [3:0]  a_fc, a_fe, b_fc, b_fe;

  checker_multi_cmp #(.DATA_WIDTH(4), .CHANNELS(4), .CNT_WIDTH(16), .ARM_DELAY(2)) dut_a (
    .clk(clk), .reset(reset), .valid_c(valid_c), .valid_e(valid_e),
    .data_c(data_c), .data_e(data_e), .ch_match(a_ch_match), .checks_out(a_checks),
    .err_pulse(a_pulse), .err_sticky(a_sticky), .mismatch_count(a_count),
    .first_err_cycle(a_fcyc), .first_err_chan(a_fchan), .first_err_c(a_fc), .first_err_e(a_fe)
  );

  checker_multi_cmp #(.DATA_WIDTH(4), .CHANNELS(4), .CNT_WIDTH(4), .ARM_DELAY(0)) dut_b (
    .clk(clk), .reset(reset), .valid_c(valid_c), .valid_e(valid_e),
    .data_c(data_c), .data_e(data_e), .ch_match(b_ch_match), .checks_out(b_checks),
    .err_pulse(b_pulse), .err_sticky(b_sticky), .mismatch_count(b_count),
    .first_err_cycle(b_fcyc), .first_err_chan(b_fchan), .first_err_c(b_fc), .first_err_e(b_fe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         since;     // clock edges since reset release
    bit         captured;
    logic [3:0] ch_match;
    bit         checks;
    bit         pulse;
    bit         sticky;
    int         count;
    int         fcycle;
    int         fchan;
    logic [3:0] fc;
    logic [3:0] fe;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, logic rst, logic [3:0] vc, logic [3:0] ve,
                                    logic [15:0] dc, logic [15:0] de, int arm, int cmax);
    mdl_t n = m;
    logic [3:0] mis;
    int first;
    int idx;
    if (rst) begin
      n.since = 0; n.captured = 0; n.ch_match = 4'hF; n.checks = 1; n.pulse = 0;
      n.sticky = 0; n.count = 0; n.fcycle = 0; n.fchan = 0; n.fc = 4'h0; n.fe = 4'h0;
      return n;
    end
    if (m.since < arm) begin
      n.since = m.since + 1;
      n.ch_match = 4'hF; n.checks = 1; n.pulse = 0;
      return n;
    end
    idx = m.since - arm;
    if (idx > cmax) idx = cmax;
    n.since = m.since + ((m.since - arm < cmax) ? 1 : 0);
    first = -1;
    for (int i = 0; i < 4; i++) begin
      mis[i] = (vc[i] !== ve[i]) || (vc[i] === 1'b1 && ve[i] === 1'b1 && dc[i*4 +: 4] !== de[i*4 +: 4]);
      if (mis[i] && first < 0) first = i;
    end
    n.ch_match = ~mis;
    n.checks = (mis == 4'h0);
    n.pulse = (mis != 4'h0);
    if (mis != 4'h0) begin
      n.sticky = 1;
      if (m.count < cmax) n.count = m.count + 1;
      if (!m.captured) begin
        n.captured = 1; n.fcycle = idx; n.fchan = first;
        n.fc = dc[first*4 +: 4]; n.fe = de[first*4 +: 4];
      end
    end
    return n;
  endfunction

  mdl_t ma, mb;
  bit go = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    ma <= mdl_step(ma, reset, valid_c, valid_e, data_c, data_e, 2, 65535);
    mb <= mdl_step(mb, reset, valid_c, valid_e, data_c, data_e, 0, 15);
    if (reset) go <= 1'b1;
  end

  always @(negedge clk) begin
    if (go) begin
      chk("a.ch_match", 32'(a_ch_match), 32'(ma.ch_match));
      chk("a.checks_out", 32'(a_checks), 32'(ma.checks));
      chk("a.err_pulse", 32'(a_pulse), 32'(ma.pulse));
      chk("a.err_sticky", 32'(a_sticky), 32'(ma.sticky));
      chk("a.mismatch_count", 32'(a_count), ma.count);
      chk("a.first_err_cycle", 32'(a_fcyc), ma.fcycle);
      chk("a.first_err_chan", 32'(a_fchan), ma.fchan);
      chk("a.first_err_c", 32'(a_fc), 32'(ma.fc));
      chk("a.first_err_e", 32'(a_fe), 32'(ma.fe));
      chk("b.ch_match", 32'(b_ch_match), 32'(mb.ch_match));
      chk("b.checks_out", 32'(b_checks), 32'(mb.checks));
      chk("b.err_pulse", 32'(b_pulse), 32'(mb.pulse));
      chk("b.err_sticky", 32'(b_sticky), 32'(mb.sticky));
      chk("b.mismatch_count", 32'(b_count), mb.count);
      chk("b.first_err_cycle", 32'(b_fcyc), mb.fcycle);
      chk("b.first_err_chan", 32'(b_fchan), mb.fchan);
      chk("b.first_err_c", 32'(b_fc), 32'(mb.fc));
      chk("b.first_err_e", 32'(b_fe), 32'(mb.fe));
    end
  end

  task automatic drive(logic [3:0] vc, logic [3:0] ve, logic [15:0] dc, logic [15:0] de);
    valid_c = vc; valid_e = ve; data_c = dc; data_e = de;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Equal data after a 3-cycle reset.
    reset = 1'b1;
    drive(4'hF, 4'hF, 16'h5555, 16'h5555);
    repeat (3) tick();
    chk("lit.reset_ch_match", 32'(a_ch_match), 32'hF);
    chk("lit.reset_count", 32'(a_count), 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    chk("lit.p1_checks_out", 32'(a_checks), 32'd1);
    chk("lit.p1_count", 32'(a_count), 32'd0);
    chk("lit.p1_sticky", 32'(a_sticky), 32'd0);

    // Mismatch while arming is ignored; the same mismatch at armed cycle 5 is captured.
    reset = 1'b1; tick(); reset = 1'b0;
    drive(4'hF, 4'hF, 16'h5525, 16'h5535);
    tick();
    chk("lit.p2_arming_count", 32'(a_count), 32'd0);
    chk("lit.p2_arming_checks", 32'(a_checks), 32'd1);
    drive(4'hF, 4'hF, 16'h5555, 16'h5555);
    repeat (6) tick();
    drive(4'hF, 4'hF, 16'h5525, 16'h5535);
    tick();
    chk("lit.p2_pulse", 32'(a_pulse), 32'd1);
    chk("lit.p2_sticky", 32'(a_sticky), 32'd1);
    chk("lit.p2_fcycle", 32'(a_fcyc), 32'd5);
    chk("lit.p2_fchan", 32'(a_fchan), 32'd1);
    chk("lit.p2_fc", 32'(a_fc), 32'h2);
    chk("lit.p2_fe", 32'(a_fe), 32'h3);
    chk("lit.p2_ch_match", 32'(a_ch_match), 32'b1101);
    chk("lit.p2_count", 32'(a_count), 32'd1);
    drive(4'hF, 4'hF, 16'h5555, 16'h5555);
    tick();
    chk("lit.p2_pulse_drop", 32'(a_pulse), 32'd0);
    chk("lit.p2_sticky_hold", 32'(a_sticky), 32'd1);

    // Channels 3 and 2 fail together at armed cycle 0.
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (2) tick();
    drive(4'hF, 4'hF, 16'h5555, 16'h7655);
    tick();
    chk("lit.p3_fchan", 32'(a_fchan), 32'd2);
    chk("lit.p3_count", 32'(a_count), 32'd1);
    chk("lit.p3_fcycle", 32'(a_fcyc), 32'd0);
    chk("lit.p3_fe", 32'(a_fe), 32'h6);
    chk("lit.p3_ch_match", 32'(a_ch_match), 32'b0011);

    // Valid mismatch with equal data, then both valids low with differing data.
    drive(4'hF, 4'hE, 16'h5555, 16'h5555);
    tick();
    chk("lit.p4_valid_mis", 32'(a_ch_match), 32'hE);
    chk("lit.p4_count", 32'(a_count), 32'd2);
    drive(4'hE, 4'hE, 16'h5551, 16'h5559);
    tick();
    chk("lit.p4_invalid_match", 32'(a_checks), 32'd1);
    chk("lit.p4_count_hold", 32'(a_count), 32'd2);

    // 20 consecutive mismatch cycles: the 4-bit counter saturates.
    drive(4'hF, 4'hF, 16'h5555, 16'hAAAA);
    repeat (20) tick();
    chk("lit.p5_b_saturate", 32'(b_count), 32'd15);
    chk("lit.p5_a_count", 32'(a_count), 32'd22);
    chk("lit.p5_a_fchan_frozen", 32'(a_fchan), 32'd2);
    chk("lit.p5_a_fc_frozen", 32'(a_fc), 32'h5);

    // Reset coincident with a mismatch while failed, then a fresh capture.
    reset = 1'b1;
    drive(4'hF, 4'hF, 16'h5555, 16'h5556);
    tick();
    chk("lit.p6_sticky", 32'(a_sticky), 32'd0);
    chk("lit.p6_count", 32'(a_count), 32'd0);
    chk("lit.p6_checks", 32'(a_checks), 32'd1);
    chk("lit.p6_fchan", 32'(a_fchan), 32'd0);
    chk("lit.p6_b_count", 32'(b_count), 32'd0);
    reset = 1'b0;
    drive(4'hF, 4'hF, 16'h5555, 16'h5555);
    repeat (3) tick();
    drive(4'hF, 4'hF, 16'h555A, 16'h555B);
    tick();
    chk("lit.p6_fcycle", 32'(a_fcyc), 32'd1);
    chk("lit.p6_fchan_new", 32'(a_fchan), 32'd0);
    chk("lit.p6_fc", 32'(a_fc), 32'hA);
    chk("lit.p6_fe", 32'(a_fe), 32'hB);
    chk("lit.p6_count_new", 32'(a_count), 32'd1);
    drive(4'hF, 4'hF, 16'h5555, 16'h5555);
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
